// File: rtl/coax_control_v2_pkg.sv
// coax_control_v2_pkg
//   Shared constants for the coax SPI command processor: opcodes, register
//   addresses, status bit positions, TX response codes and the FSM state type.
//   No ports.
package coax_control_v2_pkg;

   // Command opcodes (low nibble of the command byte)
   localparam logic [3:0] OP_READ  = 4'h2;
   localparam logic [3:0] OP_WRITE = 4'h3;
   localparam logic [3:0] OP_TX    = 4'h4;
   localparam logic [3:0] OP_RX    = 4'h5;
   localparam logic [3:0] OP_RESET = 4'hF;

   // Register addresses (high nibble of the command byte)
   localparam logic [3:0] ADDR_STATUS  = 4'h1;
   localparam logic [3:0] ADDR_CONTROL = 4'h2;
   localparam logic [3:0] ADDR_MASK    = 4'h3;
   localparam logic [3:0] ADDR_LEVEL   = 4'h4;
   localparam logic [3:0] ADDR_ID      = 4'hF;

   // Status register bit positions
   localparam int ST_TX_EMPTY    = 0;
   localparam int ST_TX_FULL     = 1;
   localparam int ST_TX_ACTIVE   = 2;
   localparam int ST_TX_COMPLETE = 3;
   localparam int ST_RX_AVAIL    = 4;
   localparam int ST_RX_ACTIVE   = 5;
   localparam int ST_RX_ERROR    = 6;

   // Response byte returned for the first byte of each TX pair
   localparam logic [7:0] TX_RESP_FULL      = 8'h81;
   localparam logic [7:0] TX_RESP_NOT_READY = 8'h82;
   localparam logic [7:0] TX_RESP_OK        = 8'h00;

   typedef enum logic [3:0] {
      S_IDLE,
      S_READ1,
      S_READ2,
      S_WRITE1,
      S_WRITE2,
      S_TX1,
      S_TX2,
      S_TX3,
      S_RX1,
      S_RX2,
      S_RX3,
      S_RX4,
      S_RESET
   } state_t;

endpackage

// File: rtl/coax_control_v2_if.sv
// coax_control_v2_if
//   Byte-level link between the SPI byte engine (master) and the command
//   processor (slave).
//   Handshake: there is no backpressure on either direction. A byte is
//   transferred in exactly the cycle its strobe is high; the receiver must
//   accept it then. spi_cs high means deselected and aborts any command.
//     spi_cs        engine -> processor  chip select, active low
//     spi_rx_data   engine -> processor  received byte
//     spi_rx_strobe engine -> processor  spi_rx_data valid, one cycle
//     spi_tx_data   processor -> engine  next response byte
//     spi_tx_strobe processor -> engine  load spi_tx_data, one cycle
interface coax_control_v2_if;
   logic       spi_cs;
   logic [7:0] spi_rx_data;
   logic       spi_rx_strobe;
   logic [7:0] spi_tx_data;
   logic       spi_tx_strobe;

   modport master (
      output spi_cs, spi_rx_data, spi_rx_strobe,
      input  spi_tx_data, spi_tx_strobe
   );

   modport slave (
      input  spi_cs, spi_rx_data, spi_rx_strobe,
      output spi_tx_data, spi_tx_strobe
   );
endinterface

// File: rtl/coax_control_v2_edge.sv
// coax_control_v2_edge
//   Single-edge detector. RISING selects a rising (1) or falling (0) edge.
//   RESET_LEVEL is the assumed previous level after reset, so an input that
//   idles at that level does not produce a spurious pulse.
//     clk, reset  clock, synchronous active-high reset
//     sig         input level
//     edge_pulse  combinational one-cycle pulse on the selected edge
module coax_control_v2_edge #(
   parameter bit RISING      = 1'b1,
   parameter bit RESET_LEVEL = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic sig,
   output logic edge_pulse
);
   logic sig_q;

   always_ff @(posedge clk) begin
      if (reset) sig_q <= RESET_LEVEL;
      else       sig_q <= sig;
   end

   assign edge_pulse = RISING ? (sig & ~sig_q) : (~sig & sig_q);
endmodule

// File: rtl/coax_control_v2.sv
// coax_control_v2
//   SPI-slave command processor between the SPI byte engine and the coax
//   TX/RX FIFOs. All outputs are registered.
//   Optional feature macro: COAX_CONTROL_IRQ_EN (irq mask register + irq port).
//   Ports:
//     clk, reset             clock, synchronous active-high reset
//     spi                    byte link to the SPI engine (slave modport)
//     control                control register
//     tx_reset/rx_reset      reset pulses to transmitter / receiver
//     tx_data, tx_load_strobe, tx_start_strobe   TX FIFO write / start
//     tx_active, tx_empty, tx_full, tx_ready     transmitter status
//     rx_active, rx_error, rx_empty, rx_data, rx_level   receiver status
//     rx_read_strobe         pop RX FIFO
//     fsm_state              current command state (debug)
//     irq                    masked interrupt (COAX_CONTROL_IRQ_EN only)
module coax_control_v2
   import coax_control_v2_pkg::*;
#(
   parameter int         DATA_WIDTH    = 10,
   parameter int         LEVEL_WIDTH   = 8,
   parameter logic [7:0] CONTROL_RESET = 8'h48,
   parameter logic [7:0] DEVICE_ID     = 8'hA5
) (
   input  logic                   clk,
   input  logic                   reset,
   coax_control_v2_if.slave       spi,
   output logic [7:0]             control,
   output logic                   tx_reset,
   input  logic                   tx_active,
   output logic [DATA_WIDTH-1:0]  tx_data,
   output logic                   tx_load_strobe,
   output logic                   tx_start_strobe,
   input  logic                   tx_empty,
   input  logic                   tx_full,
   input  logic                   tx_ready,
   output logic                   rx_reset,
   input  logic                   rx_active,
   input  logic                   rx_error,
   input  logic                   rx_empty,
   input  logic [DATA_WIDTH-1:0]  rx_data,
   output logic                   rx_read_strobe,
   input  logic [LEVEL_WIDTH-1:0] rx_level,
   output state_t                 fsm_state
`ifdef COAX_CONTROL_IRQ_EN
   ,
   output logic                   irq
`endif
);
   localparam int UW = DATA_WIDTH - 8;

   state_t          state_q, state_n;
   logic [3:0]      addr_q, addr_n;
   logic [7:0]      wmask_q, wmask_n;
   logic [7:0]      control_n;
   logic [UW-1:0]   upper_q, upper_n;
   logic            valid_q, valid_n;
   logic [15:0]     buf_q, buf_n;
   logic            tx_complete_q, tx_complete_n, tx_clear;
   logic [7:0]      spi_tx_data_n;
   logic            spi_tx_strobe_n;
   logic [DATA_WIDTH-1:0] tx_data_n;
   logic            tx_load_n, tx_reset_n, rx_reset_n, rx_read_n;
   logic [7:0]      status, reg_rd;
   logic [15:0]     rx_snap;
   logic            cs_rise, active_fall;
`ifdef COAX_CONTROL_IRQ_EN
   logic [7:0]      mask_q, mask_n;
`endif

   assign fsm_state = state_q;

   coax_control_v2_edge #(.RISING(1'b1), .RESET_LEVEL(1'b1)) u_cs_edge (
      .clk(clk), .reset(reset), .sig(spi.spi_cs), .edge_pulse(cs_rise)
   );

   coax_control_v2_edge #(.RISING(1'b0), .RESET_LEVEL(1'b0)) u_active_edge (
      .clk(clk), .reset(reset), .sig(tx_active), .edge_pulse(active_fall)
   );

   always_comb begin
      status                 = '0;
      status[ST_TX_EMPTY]    = tx_empty;
      status[ST_TX_FULL]     = tx_full;
      status[ST_TX_ACTIVE]   = tx_active;
      status[ST_TX_COMPLETE] = tx_complete_q;
      status[ST_RX_AVAIL]    = ~rx_empty;
      status[ST_RX_ACTIVE]   = rx_active;
      status[ST_RX_ERROR]    = rx_error;
   end

   always_comb begin
      case (addr_q)
         ADDR_STATUS:  reg_rd = status;
         ADDR_CONTROL: reg_rd = control;
`ifdef COAX_CONTROL_IRQ_EN
         ADDR_MASK:    reg_rd = mask_q;
`endif
         ADDR_LEVEL:   reg_rd = 8'(rx_level);
         ADDR_ID:      reg_rd = DEVICE_ID;
         default:      reg_rd = '0;
      endcase
   end

   // Flags sit in the top two bits; for words wider than 14 bits they take
   // precedence over the top data bits, which cannot fit in two bytes.
   always_comb begin
      rx_snap     = 16'(rx_data);
      rx_snap[15] = rx_error;
      rx_snap[14] = rx_empty;
   end

   always_comb begin
      state_n         = state_q;
      addr_n          = addr_q;
      wmask_n         = wmask_q;
      control_n       = control;
      upper_n         = upper_q;
      valid_n         = valid_q;
      buf_n           = buf_q;
      spi_tx_data_n   = spi.spi_tx_data;
      spi_tx_strobe_n = 1'b0;
      tx_data_n       = tx_data;
      tx_load_n       = 1'b0;
      tx_reset_n      = 1'b0;
      rx_reset_n      = 1'b0;
      rx_read_n       = 1'b0;
      tx_clear        = 1'b0;
`ifdef COAX_CONTROL_IRQ_EN
      mask_n          = mask_q;
`endif
      if (spi.spi_cs) begin
         // Deselect abandons the command and any half-received TX pair.
         state_n = S_IDLE;
         valid_n = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: if (spi.spi_rx_strobe) begin
               addr_n = spi.spi_rx_data[7:4];
               case (spi.spi_rx_data[3:0])
                  OP_READ:  state_n = S_READ1;
                  OP_WRITE: state_n = S_WRITE1;
                  OP_TX:    state_n = S_TX1;
                  OP_RX:    state_n = S_RX1;
                  OP_RESET: state_n = S_RESET;
                  default:  state_n = S_IDLE;
               endcase
            end
            S_READ1: begin
               spi_tx_data_n   = reg_rd;
               spi_tx_strobe_n = 1'b1;
               state_n         = S_READ2;
            end
            S_READ2: if (spi.spi_rx_strobe) state_n = S_READ1;
            S_WRITE1: if (spi.spi_rx_strobe) begin
               wmask_n = spi.spi_rx_data;
               state_n = S_WRITE2;
            end
            S_WRITE2: if (spi.spi_rx_strobe) begin
               if (addr_q == ADDR_CONTROL)
                  control_n = (control & ~wmask_q) | (spi.spi_rx_data & wmask_q);
`ifdef COAX_CONTROL_IRQ_EN
               if (addr_q == ADDR_MASK)
                  mask_n = (mask_q & ~wmask_q) | (spi.spi_rx_data & wmask_q);
`endif
               state_n = S_IDLE;
            end
            S_TX1: begin
               tx_clear = 1'b1;
               state_n  = S_TX2;
            end
            S_TX2: if (spi.spi_rx_strobe) begin
               spi_tx_strobe_n = 1'b1;
               valid_n         = 1'b0;
               if (tx_full)        spi_tx_data_n = TX_RESP_FULL;
               else if (!tx_ready) spi_tx_data_n = TX_RESP_NOT_READY;
               else begin
                  spi_tx_data_n = TX_RESP_OK;
                  upper_n       = spi.spi_rx_data[UW-1:0];
                  valid_n       = 1'b1;
               end
               state_n = S_TX3;
            end
            S_TX3: if (spi.spi_rx_strobe) begin
               tx_data_n = {upper_q, spi.spi_rx_data};
               tx_load_n = valid_q;
               valid_n   = 1'b0;
               state_n   = S_TX2;
            end
            S_RX1: begin
               buf_n   = rx_snap;
               state_n = S_RX2;
            end
            S_RX2: begin
               spi_tx_data_n   = buf_q[15:8];
               spi_tx_strobe_n = 1'b1;
               state_n         = S_RX3;
            end
            S_RX3: if (spi.spi_rx_strobe) begin
               spi_tx_data_n   = buf_q[7:0];
               spi_tx_strobe_n = 1'b1;
               // An errored receiver is reset instead of popped.
               if (buf_q[15])      rx_reset_n = 1'b1;
               else if (!buf_q[14]) rx_read_n = 1'b1;
               state_n = S_RX4;
            end
            S_RX4: if (spi.spi_rx_strobe) state_n = S_RX1;
            S_RESET: begin
               tx_reset_n = 1'b1;
               rx_reset_n = 1'b1;
               tx_clear   = 1'b1;
               state_n    = S_IDLE;
            end
            default: state_n = S_IDLE;
         endcase
      end
      // A completion edge in the same cycle as a clear must not be lost.
      if (active_fall)   tx_complete_n = 1'b1;
      else if (tx_clear) tx_complete_n = 1'b0;
      else               tx_complete_n = tx_complete_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q           <= S_IDLE;
         addr_q            <= '0;
         wmask_q           <= '0;
         control           <= CONTROL_RESET;
         upper_q           <= '0;
         valid_q           <= 1'b0;
         buf_q             <= '0;
         tx_complete_q     <= 1'b0;
         spi.spi_tx_data   <= '0;
         spi.spi_tx_strobe <= 1'b0;
         tx_data           <= '0;
         tx_load_strobe    <= 1'b0;
         tx_start_strobe   <= 1'b0;
         tx_reset          <= 1'b0;
         rx_reset          <= 1'b0;
         rx_read_strobe    <= 1'b0;
`ifdef COAX_CONTROL_IRQ_EN
         mask_q            <= '0;
         irq               <= 1'b0;
`endif
      end else begin
         state_q           <= state_n;
         addr_q            <= addr_n;
         wmask_q           <= wmask_n;
         control           <= control_n;
         upper_q           <= upper_n;
         valid_q           <= valid_n;
         buf_q             <= buf_n;
         tx_complete_q     <= tx_complete_n;
         spi.spi_tx_data   <= spi_tx_data_n;
         spi.spi_tx_strobe <= spi_tx_strobe_n;
         tx_data           <= tx_data_n;
         tx_load_strobe    <= tx_load_n;
         tx_start_strobe   <= cs_rise & ~tx_empty & ~tx_active;
         tx_reset          <= tx_reset_n;
         rx_reset          <= rx_reset_n;
         rx_read_strobe    <= rx_read_n;
`ifdef COAX_CONTROL_IRQ_EN
         mask_q            <= mask_n;
         irq               <= |(mask_q & {2'b0, rx_error, ~rx_empty, tx_complete_q, 3'b0});
`endif
      end
   end
endmodule

// File: tb/tb_coax_control_v2.sv
// tb_coax_control_v2
//   Self-checking bench for coax_control_v2 (default parameters). Response
//   bytes and TX FIFO words are pushed into expected queues as stimulus is
//   driven and popped by a monitor on every DUT strobe. Pulse outputs are
//   counted and compared per scenario.
//   Optional macro: COAX_CONTROL_IRQ_EN (connects irq, mask readback).
module tb_coax_control_v2;
   import coax_control_v2_pkg::*;

   localparam int DW = 10;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   coax_control_v2_if spi_bus();

   logic [7:0]    control;
   logic          tx_reset, tx_active, tx_load_strobe, tx_start_strobe;
   logic [DW-1:0] tx_data;
   logic          tx_empty, tx_full, tx_ready;
   logic          rx_reset, rx_active, rx_error, rx_empty, rx_read_strobe;
   logic [DW-1:0] rx_data;
   logic [7:0]    rx_level;
   state_t        fsm_state;
`ifdef COAX_CONTROL_IRQ_EN
   logic          irq;
`endif

   coax_control_v2 dut (
      .clk(clk), .reset(reset), .spi(spi_bus),
      .control(control), .tx_reset(tx_reset), .tx_active(tx_active),
      .tx_data(tx_data), .tx_load_strobe(tx_load_strobe),
      .tx_start_strobe(tx_start_strobe), .tx_empty(tx_empty),
      .tx_full(tx_full), .tx_ready(tx_ready), .rx_reset(rx_reset),
      .rx_active(rx_active), .rx_error(rx_error), .rx_empty(rx_empty),
      .rx_data(rx_data), .rx_read_strobe(rx_read_strobe),
      .rx_level(rx_level), .fsm_state(fsm_state)
`ifdef COAX_CONTROL_IRQ_EN
      , .irq(irq)
`endif
   );

   int checks = 0;
   int failures = 0;
   logic [7:0]    exp_q[$];
   logic [DW-1:0] exp_load_q[$];
   int n_tx_start = 0, n_tx_reset = 0, n_rx_reset = 0, n_rx_read = 0;
   logic [7:0] model_control = 8'h48;
   logic [7:0] model_mask = 8'h00;
   logic       exp_tx_complete = 1'b0;

   task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // ---- monitor / scoreboard ----
   always @(negedge clk) begin
      if (spi_bus.spi_tx_strobe === 1'b1) begin
         if (exp_q.size() == 0) check_val("spi_tx_extra", 16'(exp_q.size()), 16'd1);
         else check_val("spi_tx_data", 16'(spi_bus.spi_tx_data), 16'(exp_q.pop_front()));
      end
      if (tx_load_strobe === 1'b1) begin
         if (exp_load_q.size() == 0) check_val("tx_load_extra", 16'(exp_load_q.size()), 16'd1);
         else check_val("tx_data", 16'(tx_data), 16'(exp_load_q.pop_front()));
      end
      if (tx_start_strobe === 1'b1) n_tx_start++;
      if (tx_reset === 1'b1)        n_tx_reset++;
      if (rx_reset === 1'b1)        n_rx_reset++;
      if (rx_read_strobe === 1'b1)  n_rx_read++;
   end

   // ---- driver tasks ----
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      spi_bus.spi_rx_data   = b;
      spi_bus.spi_rx_strobe = 1'b1;
      tick(1);
      spi_bus.spi_rx_strobe = 1'b0;
      tick(2);
   endtask

   task automatic cs_low();
      spi_bus.spi_cs = 1'b0;
      tick(1);
   endtask

   task automatic cs_high();
      spi_bus.spi_cs = 1'b1;
      tick(3);
   endtask

   task automatic read_reg(input logic [3:0] addr, input logic [7:0] exp);
      cs_low();
      exp_q.push_back(exp);
      send_byte({addr, OP_READ});
      cs_high();
   endtask

   task automatic write_reg(input logic [3:0] addr, input logic [7:0] m, input logic [7:0] d);
      cs_low();
      send_byte({addr, OP_WRITE});
      send_byte(m);
      send_byte(d);
      cs_high();
   endtask

   function automatic logic [7:0] status_model();
      return {1'b0, rx_error, rx_active, ~rx_empty, exp_tx_complete, tx_active, tx_full, tx_empty};
   endfunction

   function automatic logic [15:0] rx_model();
      logic [15:0] s;
      s = 16'(rx_data);
      s[15] = rx_error;
      s[14] = rx_empty;
      return s;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int base_a, base_b;
      logic [7:0] m, d;
      logic [15:0] s;

      spi_bus.spi_cs = 1'b1; spi_bus.spi_rx_data = '0; spi_bus.spi_rx_strobe = 1'b0;
      tx_active = 0; tx_empty = 1; tx_full = 0; tx_ready = 1;
      rx_active = 0; rx_error = 0; rx_empty = 1; rx_data = '0; rx_level = '0;
      tick(3);
      reset = 1'b0;
      tick(1);

      // reset state
      check_val("rst_spi_tx_data", 16'(spi_bus.spi_tx_data), 16'h0);
      check_val("rst_spi_tx_strobe", 16'(spi_bus.spi_tx_strobe), 16'h0);
      check_val("rst_control", 16'(control), 16'h48);
      check_val("rst_tx_data", 16'(tx_data), 16'h0);
      check_val("rst_strobes", 16'({tx_load_strobe, tx_start_strobe, tx_reset, rx_reset, rx_read_strobe}), 16'h0);
      check_val("rst_state", 16'(fsm_state), 16'(S_IDLE));

      // streaming read of the device ID: one load per command/dummy byte
      cs_low();
      repeat (4) exp_q.push_back(8'hA5);
      send_byte(8'hF2);
      repeat (3) send_byte(8'h00);
      cs_high();
      check_val("read_id_drain", 16'(exp_q.size()), 16'd0);

      // masked write to control
      write_reg(4'h2, 8'h01, 8'hFF);
      model_control = 8'h49;
      check_val("control_port", 16'(control), 16'(model_control));
      read_reg(4'h2, 8'h49);

      for (int i = 0; i < 4; i++) begin
         m = 8'($urandom_range(0, 255));
         d = 8'($urandom_range(0, 255));
         write_reg(4'h2, m, d);
         model_control = (model_control & ~m) | (d & m);
         check_val("control_rand", 16'(control), 16'(model_control));
      end
      read_reg(4'h2, model_control);

      // irq mask register, level, unmapped
      write_reg(4'h3, 8'hFF, 8'h18);
`ifdef COAX_CONTROL_IRQ_EN
      model_mask = 8'h18;
`endif
      read_reg(4'h3, model_mask);
      rx_level = 8'h2B;
      read_reg(4'h4, 8'h2B);
      read_reg(4'h7, 8'h00);

      // TX pair then deselect with data waiting -> one load, one start
      base_a = n_tx_start;
      cs_low();
      send_byte({4'h0, OP_TX});
      exp_q.push_back(TX_RESP_OK);
      send_byte(8'h02);
      exp_load_q.push_back(10'h25A);
      send_byte(8'h5A);
      tx_empty = 1'b0;
      cs_high();
      tx_empty = 1'b1;
      check_val("tx_start_count", 16'(n_tx_start - base_a), 16'd1);
      check_val("tx_load_drain", 16'(exp_load_q.size()), 16'd0);

      // TX while full / not ready -> error responses, no loads
      tx_full = 1'b1;
      cs_low();
      send_byte({4'h0, OP_TX});
      exp_q.push_back(TX_RESP_FULL);
      send_byte(8'h11);
      send_byte(8'h22);
      tx_full = 1'b0; tx_ready = 1'b0;
      exp_q.push_back(TX_RESP_NOT_READY);
      send_byte(8'h33);
      send_byte(8'h44);
      tx_ready = 1'b1;
      cs_high();
      check_val("tx_err_drain", 16'(exp_q.size()), 16'd0);

      // tx_complete: set on tx_active fall, cleared by next TX command
      read_reg(4'h1, status_model());
      tx_active = 1'b1;
      tick(3);
      tx_active = 1'b0;
      tick(2);
      exp_tx_complete = 1'b1;
      read_reg(4'h1, status_model());
      cs_low();
      send_byte({4'h0, OP_TX});
      cs_high();
      exp_tx_complete = 1'b0;
      read_reg(4'h1, status_model());

      // RX: good word then errored word
      rx_data = 10'h3C1; rx_empty = 1'b0;
      base_a = n_rx_read; base_b = n_rx_reset;
      cs_low();
      s = rx_model();
      exp_q.push_back(s[15:8]);
      send_byte({4'h0, OP_RX});
      exp_q.push_back(s[7:0]);
      send_byte(8'h00);
      cs_high();
      check_val("rx_read_count", 16'(n_rx_read - base_a), 16'd1);
      check_val("rx_reset_none", 16'(n_rx_reset - base_b), 16'd0);

      rx_error = 1'b1; rx_data = 10'h0C1;
      base_a = n_rx_read; base_b = n_rx_reset;
      cs_low();
      s = rx_model();
      exp_q.push_back(s[15:8]);
      send_byte({4'h0, OP_RX});
      exp_q.push_back(s[7:0]);
      send_byte(8'h00);
      cs_high();
      check_val("rx_err_no_read", 16'(n_rx_read - base_a), 16'd0);
      check_val("rx_err_reset", 16'(n_rx_reset - base_b), 16'd1);
      rx_error = 1'b0; rx_empty = 1'b1;

      // RESET command pulses both resets
      base_a = n_tx_reset; base_b = n_rx_reset;
      cs_low();
      send_byte({4'h0, OP_RESET});
      cs_high();
      check_val("cmd_tx_reset", 16'(n_tx_reset - base_a), 16'd1);
      check_val("cmd_rx_reset", 16'(n_rx_reset - base_b), 16'd1);

      // abort after first TX byte, then a clean pair
      cs_low();
      send_byte({4'h0, OP_TX});
      exp_q.push_back(TX_RESP_OK);
      send_byte(8'h01);
      cs_high();
      cs_low();
      send_byte({4'h0, OP_TX});
      exp_q.push_back(TX_RESP_OK);
      send_byte(8'h03);
      exp_load_q.push_back(10'h37E);
      send_byte(8'h7E);
      cs_high();
      check_val("abort_load_drain", 16'(exp_load_q.size()), 16'd0);

      // reset mid-RX
      rx_data = 10'h3C1; rx_empty = 1'b0;
      base_a = n_rx_read;
      cs_low();
      s = rx_model();
      exp_q.push_back(s[15:8]);
      send_byte({4'h0, OP_RX});
      reset = 1'b1;
      tick(2);
      check_val("mid_rst_control", 16'(control), 16'h48);
      check_val("mid_rst_spi_tx_data", 16'(spi_bus.spi_tx_data), 16'h0);
      check_val("mid_rst_tx_data", 16'(tx_data), 16'h0);
      check_val("mid_rst_state", 16'(fsm_state), 16'(S_IDLE));
      check_val("mid_rst_strobes", 16'({spi_bus.spi_tx_strobe, tx_load_strobe, tx_start_strobe,
                                         tx_reset, rx_reset, rx_read_strobe}), 16'h0);
      reset = 1'b0;
      spi_bus.spi_cs = 1'b1;
      tick(3);
      check_val("mid_rst_no_read", 16'(n_rx_read - base_a), 16'd0);

      check_val("final_exp_q", 16'(exp_q.size()), 16'd0);
      check_val("final_load_q", 16'(exp_load_q.size()), 16'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
